// File: rtl/prtc_host_seq.sv
// rtl/prtc_host_seq.sv - hardware initiator for the C033/C034 PRAM/RTC command bus
//
// Runs one complete BRAM (0-255) or clock (0-3) byte transaction against the
// prtc responder without CPU help. After reset it optionally walks the
// responder back to its idle state using read-only strobes (resync).
//
// Ports:
//   CLK_14M      system clock
//   reset        synchronous, active-high
//   cen          responder clock enable; a strobe completes only when cen=1
//   req_*        request channel (valid/ready handshake, rd, clk, addr, wdata)
//   resp_valid   one-clock pulse when a transaction finishes
//   resp_rdata   last read byte, held until the next read
//   busy         high from accept (or reset) until back in IDLE
//   prtc_addr    0=C033 data, 1=C034 control
//   prtc_rw      1=read, 0=write
//   prtc_din     byte to responder
//   prtc_strobe  control strobe
//   prtc_dout    responder registered read data
module prtc_host_seq #(
  parameter bit RESYNC_ON_RESET = 1'b1
) (
  input  logic       CLK_14M,
  input  logic       reset,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic       req_clk,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       busy,
  output logic       prtc_addr,
  output logic       prtc_rw,
  output logic [7:0] prtc_din,
  output logic       prtc_strobe,
  input  logic [7:0] prtc_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_BOOT, S_PRE34, S_W33, S_STB, S_RD, S_CAP, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    K_BRD, K_BWR, K_CRD, K_CWR, K_SYNC
  } kind_t;

  state_t     state;
  state_t     nxt_state;
  kind_t      kind;
  logic [3:0] idx;
  logic [3:0] nxt_idx;
  logic       r_rd;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;

  logic [7:0] w33_byte;
  logic [7:0] bram_cmd1;
  logic [7:0] bram_cmd2;
  logic [7:0] clk_cmd;

  logic       nxt_bus_addr;
  logic       nxt_bus_rw;
  logic       nxt_bus_strobe;
  logic [7:0] nxt_bus_din;

  assign nxt_idx   = idx + 4'd1;
  assign bram_cmd1 = {~r_rd, 4'b0111, r_addr[7:5]};
  assign bram_cmd2 = {1'b0, r_addr[4:0], 2'b00};
  assign clk_cmd   = {r_rd, 3'b000, r_addr[1:0], 2'b01};

  // Step table: which bus state (and C033 byte) each sequence uses at step nxt_idx.
  always_comb begin : step_table
    nxt_state = S_DONE;
    w33_byte  = 8'h00;
    case (kind)
      K_BRD: begin
        case (nxt_idx)
          4'd0:             nxt_state = S_PRE34;
          4'd1:             begin nxt_state = S_W33; w33_byte = bram_cmd1; end
          4'd2, 4'd4, 4'd5: nxt_state = S_STB;
          4'd3:             begin nxt_state = S_W33; w33_byte = bram_cmd2; end
          4'd6:             nxt_state = S_RD;
          4'd7:             nxt_state = S_CAP;
          default:          nxt_state = S_DONE;
        endcase
      end
      K_BWR: begin
        case (nxt_idx)
          4'd0:             nxt_state = S_PRE34;
          4'd1:             begin nxt_state = S_W33; w33_byte = bram_cmd1; end
          4'd2, 4'd4, 4'd6: nxt_state = S_STB;
          4'd3:             begin nxt_state = S_W33; w33_byte = bram_cmd2; end
          4'd5:             begin nxt_state = S_W33; w33_byte = r_wdata; end
          default:          nxt_state = S_DONE;
        endcase
      end
      K_CRD: begin
        case (nxt_idx)
          4'd0:       nxt_state = S_PRE34;
          4'd1:       begin nxt_state = S_W33; w33_byte = clk_cmd; end
          4'd2, 4'd3: nxt_state = S_STB;
          4'd4:       nxt_state = S_RD;
          4'd5:       nxt_state = S_CAP;
          default:    nxt_state = S_DONE;
        endcase
      end
      K_CWR: begin
        case (nxt_idx)
          4'd0:       nxt_state = S_PRE34;
          4'd1:       begin nxt_state = S_W33; w33_byte = clk_cmd; end
          4'd2, 4'd4: nxt_state = S_STB;
          4'd3:       begin nxt_state = S_W33; w33_byte = r_wdata; end
          default:    nxt_state = S_DONE;
        endcase
      end
      K_SYNC: begin
        // 8'h00 matches no command, so three read strobes drain any
        // partially entered command without writing anything.
        case (nxt_idx)
          4'd0:             nxt_state = S_PRE34;
          4'd1:             begin nxt_state = S_W33; w33_byte = 8'h00; end
          4'd2, 4'd3, 4'd4: nxt_state = S_STB;
          default:          nxt_state = S_IDLE;
        endcase
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Bus values for the state being entered. Only PRE34/W33/STB write;
  // the responder latches C033/C034 on any write cycle.
  always_comb begin : bus_for_next
    nxt_bus_addr   = 1'b0;
    nxt_bus_rw     = 1'b1;
    nxt_bus_strobe = 1'b0;
    nxt_bus_din    = 8'h00;
    case (nxt_state)
      S_PRE34: begin
        nxt_bus_addr = 1'b1;
        nxt_bus_rw   = 1'b0;
        nxt_bus_din  = {1'b0, r_rd, 6'b000000};
      end
      S_W33: begin
        nxt_bus_rw  = 1'b0;
        nxt_bus_din = w33_byte;
      end
      S_STB: begin
        nxt_bus_addr   = 1'b1;
        nxt_bus_rw     = 1'b0;
        nxt_bus_strobe = 1'b1;
        nxt_bus_din    = {1'b1, r_rd, 6'b000000};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_14M) begin
    if (reset) begin
      if (RESYNC_ON_RESET) begin
        state     <= S_BOOT;
        req_ready <= 1'b0;
        busy      <= 1'b1;
      end else begin
        state     <= S_IDLE;
        req_ready <= 1'b1;
        busy      <= 1'b0;
      end
      kind        <= K_SYNC;
      idx         <= 4'hF;          // wraps to step 0 on the first advance
      r_rd        <= 1'b1;          // resync uses read strobes only
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      resp_valid  <= 1'b0;
      resp_rdata  <= 8'h00;
      prtc_addr   <= 1'b0;
      prtc_rw     <= 1'b1;
      prtc_din    <= 8'h00;
      prtc_strobe <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_rd    <= req_rd;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (req_clk) begin
              if (req_rd) kind <= K_CRD;
              else        kind <= K_CWR;
            end else begin
              if (req_rd) kind <= K_BRD;
              else        kind <= K_BWR;
            end
            idx         <= 4'd0;
            state       <= S_PRE34;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            // PRE34 bus values come straight from the request; r_rd is not loaded yet.
            prtc_addr   <= 1'b1;
            prtc_rw     <= 1'b0;
            prtc_din    <= {1'b0, req_rd, 6'b000000};
            prtc_strobe <= 1'b0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          // STB is held until the responder actually sees a cen cycle.
          if (state != S_STB || cen) begin
            if (state == S_CAP) resp_rdata <= prtc_dout;
            idx         <= nxt_idx;
            state       <= nxt_state;
            prtc_addr   <= nxt_bus_addr;
            prtc_rw     <= nxt_bus_rw;
            prtc_din    <= nxt_bus_din;
            prtc_strobe <= nxt_bus_strobe;
            if (nxt_state == S_DONE) resp_valid <= 1'b1;
            if (nxt_state == S_IDLE) begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
